// File: rtl/reg_scoreboard_pkg.sv
// Shared CPU-side definitions for the register scoreboard: default register-file
// geometry and the busy-counter update encoding.
package reg_scoreboard_pkg;

  localparam int DEFAULT_ADDR_W   = 5;
  localparam bit DEFAULT_ZERO_REG = 1'b1;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/reg_scoreboard_bin_onehot_dec.sv
// Binary index to one-hot mask decoder with enable; optionally treats index 0
// as a hardwired register that never produces a mask bit.
module bin_onehot_dec
  import reg_scoreboard_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit ZERO_REG = DEFAULT_ZERO_REG
) (
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(2**ADDR_W)-1:0]   mask
);

  localparam int NREG = 2**ADDR_W;

  logic addr_zero_s;

  assign addr_zero_s = ZERO_REG && (addr == {ADDR_W{1'b0}});

  // One-hot decode, suppressed when disabled or for the hardwired zero register
  always_comb begin
    mask = {NREG{1'b0}};
    if (en && !addr_zero_s) begin
      mask[addr] = 1'b1;
    end else begin
      mask = {NREG{1'b0}};
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks destination registers with a pending write,
// stalls WAW issues, flags RAW hazards on two sources and bad retires.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit ZERO_REG = DEFAULT_ZERO_REG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic                    iss_ready,
  input  logic                    ret_valid,
  input  logic [ADDR_W-1:0]       ret_addr,
  input  logic [ADDR_W-1:0]       rs1_addr,
  input  logic [ADDR_W-1:0]       rs2_addr,
  output logic                    rs1_hazard,
  output logic                    rs2_hazard,
  output logic [(2**ADDR_W)-1:0]  busy,
  output logic [ADDR_W:0]         busy_cnt,
  output logic                    err_ret
);

  localparam int             NREG    = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(NREG);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [NREG-1:0] busy_q, busy_d;
  logic [ADDR_W:0] busy_cnt_q, busy_cnt_d;
  logic            err_ret_q, err_ret_d;

  logic [NREG-1:0] fire_mask_s;
  logic [NREG-1:0] ret_mask_s;
  logic [NREG-1:0] valid_ret_mask_s;
  logic            fire_s;
  logic            fire_eff_s;
  logic            ret_eff_s;
  logic            iss_zero_s;
  logic            ret_zero_s;
  logic            rs1_zero_s;
  logic            rs2_zero_s;
  cnt_op_e         cnt_op_s;

  assign iss_zero_s = ZERO_REG && (iss_addr == {ADDR_W{1'b0}});
  assign ret_zero_s = ZERO_REG && (ret_addr == {ADDR_W{1'b0}});
  assign rs1_zero_s = ZERO_REG && (rs1_addr == {ADDR_W{1'b0}});
  assign rs2_zero_s = ZERO_REG && (rs2_addr == {ADDR_W{1'b0}});

  // WAW stall from current state only; a same-cycle retire does not bypass
  assign iss_ready = !rst && (iss_zero_s || !busy_q[iss_addr]);
  assign fire_s    = iss_valid && iss_ready;

  bin_onehot_dec #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_iss_dec (
    .en   (fire_s),
    .addr (iss_addr),
    .mask (fire_mask_s)
  );

  bin_onehot_dec #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_ret_dec (
    .en   (ret_valid),
    .addr (ret_addr),
    .mask (ret_mask_s)
  );

  assign valid_ret_mask_s = ret_mask_s & busy_q;
  assign fire_eff_s       = |fire_mask_s;
  assign ret_eff_s        = |valid_ret_mask_s;

  assign rs1_hazard = !rs1_zero_s && busy_q[rs1_addr];
  assign rs2_hazard = !rs2_zero_s && busy_q[rs2_addr];

  // Next busy vector and retire-error flag
  always_comb begin
    busy_d    = (busy_q & ~valid_ret_mask_s) | fire_mask_s;
    err_ret_d = 1'b0;
    if (ret_valid && !ret_zero_s && !busy_q[ret_addr]) begin
      err_ret_d = 1'b1;
    end else begin
      err_ret_d = 1'b0;
    end
  end

  // Classify the counter update; issue and retire together cancel out
  always_comb begin
    cnt_op_s = CNT_HOLD;
    case ({fire_eff_s, ret_eff_s})
      2'b10:   cnt_op_s = CNT_INC;
      2'b01:   cnt_op_s = CNT_DEC;
      default: cnt_op_s = CNT_HOLD;
    endcase
  end

  // Saturating incremental counter so it can never wrap
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    case (cnt_op_s)
      CNT_INC: begin
        if (busy_cnt_q < CNT_MAX) begin
          busy_cnt_d = busy_cnt_q + CNT_ONE;
        end else begin
          busy_cnt_d = busy_cnt_q;
        end
      end
      CNT_DEC: begin
        if (busy_cnt_q != {(ADDR_W+1){1'b0}}) begin
          busy_cnt_d = busy_cnt_q - CNT_ONE;
        end else begin
          busy_cnt_d = busy_cnt_q;
        end
      end
      default: busy_cnt_d = busy_cnt_q;
    endcase
  end

  // State registers; reset overrides any same-cycle issue or retire
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= {NREG{1'b0}};
      busy_cnt_q <= {(ADDR_W+1){1'b0}};
      err_ret_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      err_ret_q  <= err_ret_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;
  assign err_ret  = err_ret_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with the default geometry
// (32 registers, register 0 hardwired).
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic        ret_valid;
  logic [4:0]  ret_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_hazard;
  logic        rs2_hazard;
  logic [31:0] busy;
  logic [5:0]  busy_cnt;
  logic        err_ret;

  int checks;
  int errors;

  reg_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .iss_ready  (iss_ready),
    .ret_valid  (ret_valid),
    .ret_addr   (ret_addr),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_hazard (rs1_hazard),
    .rs2_hazard (rs2_hazard),
    .busy       (busy),
    .busy_cnt   (busy_cnt),
    .err_ret    (err_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after an edge and let combinational outputs settle
  task automatic drive(input logic iv, input logic [4:0] ia, input logic rv, input logic [4:0] ra);
    iss_valid = iv;
    iss_addr  = ia;
    ret_valid = rv;
    ret_addr  = ra;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    drive(1'b0, 5'd0, 1'b0, 5'd0);

    // Reset with issue and bad retire requested at the same time
    drive(1'b1, 5'd5, 1'b1, 5'd9);
    check("rst_iss_ready", iss_ready, 64'd0);
    tick();
    tick();
    check("rst_busy", busy, 64'd0);
    check("rst_cnt", busy_cnt, 64'd0);
    check("rst_err", err_ret, 64'd0);

    rst = 1'b0;
    drive(1'b1, 5'd5, 1'b0, 5'd0);
    check("iss5_ready", iss_ready, 64'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    rs1_addr = 5'd5;
    rs2_addr = 5'd6;
    #1;
    check("iss5_busy", busy, 64'h0000_0020);
    check("iss5_cnt", busy_cnt, 64'd1);
    check("iss5_rs1_haz", rs1_hazard, 64'd1);
    check("iss5_rs2_haz", rs2_hazard, 64'd0);

    // WAW stall on 5, then stall plus retire of 5
    drive(1'b1, 5'd5, 1'b0, 5'd0);
    check("waw_ready", iss_ready, 64'd0);
    tick();
    check("waw_busy", busy, 64'h0000_0020);
    check("waw_cnt", busy_cnt, 64'd1);
    drive(1'b1, 5'd5, 1'b1, 5'd5);
    check("waw_ret_ready", iss_ready, 64'd0);
    tick();
    check("waw_ret_busy", busy, 64'd0);
    check("waw_ret_cnt", busy_cnt, 64'd0);
    check("waw_ret_err", err_ret, 64'd0);

    // Issue 7 while retiring busy 3
    drive(1'b1, 5'd3, 1'b0, 5'd0);
    tick();
    check("iss3_busy", busy, 64'h0000_0008);
    drive(1'b1, 5'd7, 1'b1, 5'd3);
    tick();
    rs2_addr = 5'd7;
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    check("i7r3_busy", busy, 64'h0000_0080);
    check("i7r3_cnt", busy_cnt, 64'd1);
    check("i7r3_err", err_ret, 64'd0);
    check("i7r3_rs2_haz", rs2_hazard, 64'd1);

    // Retire of a non-busy register pulses err_ret for one cycle
    drive(1'b0, 5'd0, 1'b1, 5'd9);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    check("r9_err", err_ret, 64'd1);
    check("r9_busy", busy, 64'h0000_0080);
    check("r9_cnt", busy_cnt, 64'd1);
    tick();
    check("r9_err_clr", err_ret, 64'd0);

    // Register 0 is inert
    rs1_addr = 5'd0;
    drive(1'b1, 5'd0, 1'b1, 5'd0);
    check("z_ready", iss_ready, 64'd1);
    check("z_rs1_haz", rs1_hazard, 64'd0);
    tick();
    check("z_busy", busy, 64'h0000_0080);
    check("z_cnt", busy_cnt, 64'd1);
    check("z_err", err_ret, 64'd0);

    // Same-register issue and retire while not busy: issue lands and err_ret
    drive(1'b1, 5'd4, 1'b1, 5'd4);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    check("same4_busy", busy, 64'h0000_0090);
    check("same4_cnt", busy_cnt, 64'd2);
    check("same4_err", err_ret, 64'd1);
    drive(1'b0, 5'd0, 1'b1, 5'd7);
    tick();
    drive(1'b0, 5'd0, 1'b1, 5'd4);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    check("clean_busy", busy, 64'd0);
    check("clean_cnt", busy_cnt, 64'd0);

    // Fill every register 1..31
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 1'b0, 5'd0);
      tick();
      check("fill_cnt", busy_cnt, 64'(i));
    end
    drive(1'b1, 5'd31, 1'b0, 5'd0);
    check("full_ready31", iss_ready, 64'd0);
    check("full_busy", busy, 64'hFFFF_FFFE);
    check("full_cnt", busy_cnt, 64'd31);

    // Reset mid-sequence overrides a concurrent retire
    rst = 1'b1;
    rs1_addr = 5'd2;
    drive(1'b1, 5'd31, 1'b1, 5'd5);
    check("mid_rst_ready", iss_ready, 64'd0);
    tick();
    check("mid_rst_busy", busy, 64'd0);
    check("mid_rst_cnt", busy_cnt, 64'd0);
    check("mid_rst_haz", rs1_hazard, 64'd0);
    rst = 1'b0;
    drive(1'b1, 5'd2, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    check("post_rst_busy", busy, 64'h0000_0004);
    check("post_rst_cnt", busy_cnt, 64'd1);
    check("post_rst_haz", rs1_hazard, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
